// File: rtl/md_sched_pkg.sv
// Shared encodings for the multiply/divide sequencer: MD opcodes, FSM states
// and a small magnitude helper used by the divider.
package md_sched_pkg;

  localparam int MD_OP_W = 3;

  typedef enum logic [MD_OP_W-1:0] {
    MD_NONE  = 3'd0,
    MD_MULT  = 3'd1,
    MD_MULTU = 3'd2,
    MD_DIV   = 3'd3,
    MD_DIVU  = 3'd4,
    MD_MTHI  = 3'd5,
    MD_MTLO  = 3'd6
  } md_op_e;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_RUN  = 1'b1
  } md_state_e;

  function automatic logic [31:0] mag32(input logic [31:0] v);
    return v[31] ? -v : v;
  endfunction

endpackage

// File: rtl/md_sched_if.sv
// Issue/result bundle between the E-stage and the MD sequencer.
interface md_sched_if;
  import md_sched_pkg::*;

  logic                 start;
  logic [MD_OP_W-1:0]   op;
  logic [31:0]          rs_val;
  logic [31:0]          rt_val;
  logic                 md_d;
  logic                 busy;
  logic                 md_stall;
  logic [31:0]          hi;
  logic [31:0]          lo;

  modport master (
    output start, op, rs_val, rt_val, md_d,
    input  busy, md_stall, hi, lo
  );

  modport slave (
    input  start, op, rs_val, rt_val, md_d,
    output busy, md_stall, hi, lo
  );

endinterface

// File: rtl/md_sched_arith.sv
// Combinational multiply/divide datapath; res_valid drops on divide-by-zero so
// the sequencer can leave HI/LO untouched.
module md_arith
  import md_sched_pkg::*;
(
  input  logic [MD_OP_W-1:0] op,
  input  logic [31:0]        rs_val,
  input  logic [31:0]        rt_val,
  output logic [31:0]        res_hi,
  output logic [31:0]        res_lo,
  output logic               res_valid
);

  logic [63:0] prod_s;
  logic [63:0] prod_u;
  logic [31:0] safe_rt;
  logic [31:0] dvd_mag;
  logic [31:0] dvs_mag;
  logic [31:0] q_mag;
  logic [31:0] r_mag;
  logic [31:0] uq;
  logic [31:0] ur;

  // Low 64 bits of a sign-extended product equal the signed 32x32 product.
  assign prod_s = {{32{rs_val[31]}}, rs_val} * {{32{rt_val[31]}}, rt_val};
  assign prod_u = {32'd0, rs_val} * {32'd0, rt_val};

  // A zero divisor is replaced so no x/0 is ever evaluated; res_valid discards it.
  assign safe_rt = (rt_val == 32'd0) ? 32'd1 : rt_val;
  assign dvd_mag = mag32(rs_val);
  assign dvs_mag = mag32(safe_rt);
  assign q_mag   = dvd_mag / dvs_mag;
  assign r_mag   = dvd_mag % dvs_mag;
  assign uq      = rs_val / safe_rt;
  assign ur      = rs_val % safe_rt;

  always_comb begin
    res_hi    = '0;
    res_lo    = '0;
    res_valid = 1'b0;
    case (op)
      MD_MULT: begin
        {res_hi, res_lo} = prod_s;
        res_valid        = 1'b1;
      end
      MD_MULTU: begin
        {res_hi, res_lo} = prod_u;
        res_valid        = 1'b1;
      end
      MD_DIV: begin
        res_lo    = (rs_val[31] ^ rt_val[31]) ? -q_mag : q_mag;
        res_hi    = rs_val[31] ? -r_mag : r_mag;
        res_valid = |rt_val;
      end
      MD_DIVU: begin
        res_lo    = uq;
        res_hi    = ur;
        res_valid = |rt_val;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/md_sched.sv
// Multi-cycle MD sequencer: owns HI/LO, holds busy for a fixed latency per op
// and raises the stall request for MD instructions waiting in Decode.
module md_sched
  import md_sched_pkg::*;
#(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10,
  parameter int CNT_W       = 4
) (
  input logic        clk,
  input logic        reset,
  md_sched_if.slave  bus
);

  localparam logic [CNT_W-1:0] MULT_CNT = CNT_W'(MULT_CYCLES);
  localparam logic [CNT_W-1:0] DIV_CNT  = CNT_W'(DIV_CYCLES);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(1);

  md_state_e        state;
  logic [CNT_W-1:0] cnt;
  logic             busy_q;
  logic [31:0]      hi_q;
  logic [31:0]      lo_q;
  logic [31:0]      pend_hi;
  logic [31:0]      pend_lo;
  logic             pend_valid;

  logic [31:0]      res_hi;
  logic [31:0]      res_lo;
  logic             res_valid;

  md_arith u_arith (
    .op        (bus.op),
    .rs_val    (bus.rs_val),
    .rt_val    (bus.rt_val),
    .res_hi    (res_hi),
    .res_lo    (res_lo),
    .res_valid (res_valid)
  );

  // Starts are only honoured in IDLE, so a start can never collide with a commit.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= S_IDLE;
      cnt        <= '0;
      busy_q     <= 1'b0;
      hi_q       <= '0;
      lo_q       <= '0;
      pend_hi    <= '0;
      pend_lo    <= '0;
      pend_valid <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (bus.start) begin
            case (bus.op)
              MD_MULT, MD_MULTU: begin
                pend_hi    <= res_hi;
                pend_lo    <= res_lo;
                pend_valid <= res_valid;
                cnt        <= MULT_CNT;
                busy_q     <= 1'b1;
                state      <= S_RUN;
              end
              MD_DIV, MD_DIVU: begin
                pend_hi    <= res_hi;
                pend_lo    <= res_lo;
                pend_valid <= res_valid;
                cnt        <= DIV_CNT;
                busy_q     <= 1'b1;
                state      <= S_RUN;
              end
              MD_MTHI: hi_q <= bus.rs_val;
              MD_MTLO: lo_q <= bus.rs_val;
              default: ;
            endcase
          end
        end
        S_RUN: begin
          cnt <= cnt - LAST_CNT;
          if (cnt == LAST_CNT) begin
            if (pend_valid) begin
              hi_q <= pend_hi;
              lo_q <= pend_lo;
            end
            busy_q <= 1'b0;
            state  <= S_IDLE;
          end
        end
      endcase
    end
  end

  assign bus.busy     = busy_q;
  assign bus.hi       = hi_q;
  assign bus.lo       = lo_q;
  assign bus.md_stall = bus.md_d & (bus.start | busy_q);

endmodule

// File: doc/md_sched.md
Name: md_sched

Overview:
- Multi-cycle multiply/divide sequencer for the 5-stage pipeline. Sits beside Execute and owns the HI/LO registers.
- Accepts one MD operation per issue from E-stage and holds `busy` for a fixed latency before committing HI/LO.
- Produces the stall request that the hazard unit ORs into its EnPC/EnIFID/FlushIDEX logic whenever the D-stage instruction uses the MD unit.

Parameters:
- MULT_CYCLES, 5, busy cycles for mult/multu (>=1)
- DIV_CYCLES, 10, busy cycles for div/divu (>=1)
- CNT_W, 4, counter width; must hold max(MULT_CYCLES, DIV_CYCLES)

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- start  in  1  E-stage holds an MD instruction this cycle (single-cycle qualifier)
- op  in  3  MD opcode from shared package, valid when start=1
- rs_val  in  32  forwarded rs operand (FwdE1 value)
- rt_val  in  32  forwarded rt operand (FwdE2 value)
- md_d  in  1  D-stage instruction is mult/multu/div/divu/mfhi/mflo/mthi/mtlo
- busy  out  1  an operation is in flight
- md_stall  out  1  stall request to hazard unit
- hi  out  32  architectural HI
- lo  out  32  architectural LO

Behaviour:
- Reset (async, immediate): state=IDLE, cnt=0, busy=0, hi=0, lo=0, pend_hi=0, pend_lo=0. Reset mid-operation discards the pending result.
- States:
  - IDLE: busy=0.
  - RUN: busy=1.
- IDLE, start=1, op MULT/MULTU:
  - latch {pend_hi,pend_lo} = 64-bit product (signed/unsigned per op)
  - cnt<=MULT_CYCLES, go RUN
- IDLE, start=1, op DIV/DIVU:
  - latch pend_lo=quotient, pend_hi=remainder
  - cnt<=DIV_CYCLES, go RUN
- IDLE, start=1, op MTHI/MTLO:
  - hi (or lo) <= rs_val on this edge
  - no busy, stay IDLE
- op NONE or undefined with start=1: no effect.
- RUN:
  - cnt decrements each edge.
  - On the edge where cnt==1: hi<=pend_hi, lo<=pend_lo, busy drops, go IDLE.
  - busy is therefore high for exactly N cycles, starting the cycle after start.
  - HI/LO change only on that final edge.
- start while RUN: ignored, no restart and no HI/LO write. The hazard unit guarantees this cannot occur; the bench flags it.
- Start and commit are never on the same edge, because start is only accepted in IDLE.
- md_stall = md_d & (start | busy), combinational.
  - Covers the issue cycle, when busy is still 0.
  - Also covers mf*/mt* that are waiting behind an in-flight op.
- Signed arithmetic:
  - Quotient truncates toward zero; remainder takes the dividend's sign.
  - 0x80000000 / 0xFFFFFFFF: lo=0x80000000, hi=0.
- Divide by zero (either signedness):
  - The busy period still runs for DIV_CYCLES.
  - HI/LO are left unchanged at commit.
  - A pend_valid flag is cleared to achieve this.
- hi/lo are registered outputs. Execute muxes them for mfhi/mflo; no internal bypass of the pending values.

Decomposition:
- macros.v (shared) gains:
  - MD op codes: MD_NONE=3'd0, MD_MULT=1, MD_MULTU=2, MD_DIV=3, MD_DIVU=4, MD_MTHI=5, MD_MTLO=6
  - state codes: S_IDLE=1'b0, S_RUN=1'b1
- One natural sub-module, md_arith: purely combinational.
  - Inputs: op, rs_val, rt_val.
  - Outputs: res_hi, res_lo, res_valid (0 on divide-by-zero).
- md_sched keeps the FSM, counter, pending registers, HI/LO and stall logic.

Test Plan:
- mult 0xFFFFFFFF x 0x00000002 (signed):
  - busy high for exactly 5 cycles after start
  - then hi=0xFFFFFFFF, lo=0xFFFFFFFE
  - multu with the same operands gives hi=0x00000001, lo=0xFFFFFFFE
- div -7 / 2:
  - busy for 10 cycles
  - then lo=0xFFFFFFFD (-3), hi=0xFFFFFFFF (-1)
  - divu 7/2 gives lo=3, hi=1
- hi=0x1234, lo=0x5678 preloaded via mthi/mtlo, then div 5/0:
  - busy still 10 cycles
  - hi/lo remain 0x1234/0x5678
- md_d=1 during the start cycle and all busy cycles of a mult:
  - md_stall=1 for 6 consecutive cycles, then 0
  - md_d=0 throughout gives md_stall=0
- reset pulsed asynchronously at busy cycle 3 of a div:
  - busy, hi, lo go 0 immediately
  - no later commit
- mthi rs_val=0xDEADBEEF while IDLE:
  - hi=0xDEADBEEF on the next edge
  - busy never asserts
  - a second start during RUN (forced) leaves cnt and the result unchanged
